// File: rtl/fetch_stage_ifid_if.sv
// Front-end bus between the fetch stage and its surroundings: redirect/stall
// inputs, instruction-memory port and the IF/ID latch outputs.
interface fetch_stage_ifid_if #(
  parameter int unsigned CNT_W = 16
);
  logic             Stall;
  logic             JumpControl;
  logic [31:0]      JumpAddress;
  logic             BranchTaken;
  logic [31:0]      BranchTarget;
  logic [31:0]      IMemAddr;
  logic [31:0]      IMemData;
  logic [31:0]      PCResult;
  logic [31:0]      Out_Instruction;
  logic [31:0]      Out_PC;
  logic [31:0]      Out_PCAdder;
  logic             Out_Valid;
  logic [CNT_W-1:0] Out_FlushCount;

  modport slave (
    input  Stall, JumpControl, JumpAddress, BranchTaken, BranchTarget, IMemData,
    output IMemAddr, PCResult, Out_Instruction, Out_PC, Out_PCAdder, Out_Valid,
           Out_FlushCount
  );

  modport master (
    output Stall, JumpControl, JumpAddress, BranchTaken, BranchTarget, IMemData,
    input  IMemAddr, PCResult, Out_Instruction, Out_PC, Out_PCAdder, Out_Valid,
           Out_FlushCount
  );
endinterface

// File: rtl/fetch_stage_ifid.sv
// MIPS front end: PC register, next-PC selection and the IF/ID pipeline latch,
// with a saturating count of IF/ID flushes.
module fetch_stage_ifid #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              ClockIn,
  input  logic              Reset,
  fetch_stage_ifid_if.slave bus
);

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_JUMP,
    SEL_BRANCH
  } sel_e;

  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [31:0]      r_id_pc;
  logic [31:0]      r_id_pc4;
  logic             r_valid;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_branch_tgt;
  logic [31:0]      w_jump_tgt;
  logic             w_flush;
  sel_e             w_sel;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_branch_tgt = {bus.BranchTarget[31:2], 2'b00};
  assign w_jump_tgt   = {bus.JumpAddress[31:2], 2'b00};

  // Stall is tested before jump: a stalled jump is ignored and reasserts later,
  // while a branch belongs to an older instruction and beats both.
  always_comb begin
    w_sel = SEL_SEQ;
    if (bus.BranchTaken) begin
      w_sel = SEL_BRANCH;
    end else if (bus.Stall) begin
      w_sel = SEL_HOLD;
    end else if (bus.JumpControl) begin
      w_sel = SEL_JUMP;
    end
  end

  assign w_flush = (w_sel == SEL_BRANCH) || (w_sel == SEL_JUMP);

  always_ff @(posedge ClockIn) begin
    if (!Reset) begin
      r_pc     <= RESET_PC;
      r_instr  <= NOP_INSTR;
      r_id_pc  <= '0;
      r_id_pc4 <= '0;
      r_valid  <= 1'b0;
    end else begin
      unique case (w_sel)
        SEL_BRANCH, SEL_JUMP: begin
          r_pc     <= (w_sel == SEL_BRANCH) ? w_branch_tgt : w_jump_tgt;
          r_instr  <= NOP_INSTR;
          r_id_pc  <= '0;
          r_id_pc4 <= '0;
          r_valid  <= 1'b0;
        end
        SEL_HOLD: begin
          r_pc     <= r_pc;
          r_instr  <= r_instr;
          r_id_pc  <= r_id_pc;
          r_id_pc4 <= r_id_pc4;
          r_valid  <= r_valid;
        end
        default: begin
          r_pc     <= w_pc_plus4;
          r_instr  <= bus.IMemData;
          r_id_pc  <= r_pc;
          r_id_pc4 <= w_pc_plus4;
          r_valid  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge ClockIn) begin
    if (!Reset) begin
      r_flush_cnt <= '0;
    end else if (w_flush && (r_flush_cnt != '1)) begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.IMemAddr        = r_pc;
  assign bus.PCResult        = r_pc;
  assign bus.Out_Instruction = r_instr;
  assign bus.Out_PC          = r_id_pc;
  assign bus.Out_PCAdder     = r_id_pc4;
  assign bus.Out_Valid       = r_valid;
  assign bus.Out_FlushCount  = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage_ifid.sv
// Bench for fetch_stage_ifid: directed vector table, randomized run against a
// behavioural model, and a long flush run for counter saturation.
module tb_fetch_stage_ifid;

  logic ClockIn;
  logic Reset;
  int   n_pass;
  int   n_total;

  fetch_stage_ifid_if #(.CNT_W(16)) bus ();

  fetch_stage_ifid #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000),
    .CNT_W    (16)
  ) dut (
    .ClockIn(ClockIn),
    .Reset  (Reset),
    .bus    (bus.slave)
  );

  initial ClockIn = 1'b0;
  always #5 ClockIn = ~ClockIn;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2008_0005;
      32'h4:   return 32'h0C00_0010;
      32'h8:   return 32'h0000_0000;
      default: return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  always_comb bus.IMemData = memf(bus.IMemAddr);

  // Behavioural model: architectural view of PC and IF/ID contents
  logic [31:0] m_pc, m_instr, m_opc, m_opa;
  logic        m_valid;
  int          m_cnt;

  task automatic model_step();
    logic [31:0] pc4;
    pc4 = m_pc + 32'd4;
    if (!Reset) begin
      m_pc = 0; m_instr = 0; m_opc = 0; m_opa = 0; m_valid = 0; m_cnt = 0;
    end else if (bus.BranchTaken || (bus.JumpControl && !bus.Stall)) begin
      m_pc    = (bus.BranchTaken ? bus.BranchTarget : bus.JumpAddress) & 32'hFFFF_FFFC;
      m_instr = 0; m_opc = 0; m_opa = 0; m_valid = 0;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else if (!bus.Stall) begin
      m_instr = memf(m_pc);
      m_opc   = m_pc;
      m_opa   = pc4;
      m_valid = 1;
      m_pc    = pc4;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".PCResult"}, bus.PCResult, m_pc);
    chk({tag, ".IMemAddr"}, bus.IMemAddr, m_pc);
    chk({tag, ".Instr"}, bus.Out_Instruction, m_instr);
    chk({tag, ".OutPC"}, bus.Out_PC, m_opc);
    chk({tag, ".OutPCAdder"}, bus.Out_PCAdder, m_opa);
    chk({tag, ".Valid"}, {31'd0, bus.Out_Valid}, {31'd0, m_valid});
    chk({tag, ".FlushCnt"}, {16'd0, bus.Out_FlushCount}, m_cnt[31:0]);
  endtask

  task automatic drive(input logic rst, input logic st, input logic jc, input logic [31:0] ja,
                       input logic bt, input logic [31:0] btg);
    Reset            = rst;
    bus.Stall        = st;
    bus.JumpControl  = jc;
    bus.JumpAddress  = ja;
    bus.BranchTaken  = bt;
    bus.BranchTarget = btg;
  endtask

  task automatic tick();
    model_step();
    @(posedge ClockIn);
    #1;
  endtask

  typedef struct {
    logic        rst, st, jc, bt;
    logic [31:0] ja, btg;
    logic [31:0] e_pc, e_instr, e_opc, e_opa;
    logic        e_valid;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[17];

  initial begin
    n_pass = 0;
    n_total = 0;
    m_pc = 0; m_instr = 0; m_opc = 0; m_opa = 0; m_valid = 0; m_cnt = 0;
    drive(0, 1, 1, 32'h200, 1, 32'h100);

    //         rst st jc bt  ja            btg           pc            instr         opc           opa          v  cnt
    vt[0]  = '{0, 1, 1, 1, 32'h200,      32'h100,      32'h0,        32'h0,        32'h0,        32'h0,       0, 0};
    vt[1]  = '{0, 1, 1, 1, 32'h200,      32'h100,      32'h0,        32'h0,        32'h0,        32'h0,       0, 0};
    vt[2]  = '{1, 0, 0, 0, 32'h0,        32'h0,        32'h4,        32'h20080005, 32'h0,        32'h4,       1, 0};
    vt[3]  = '{1, 0, 0, 0, 32'h0,        32'h0,        32'h8,        32'h0C000010, 32'h4,        32'h8,       1, 0};
    vt[4]  = '{1, 0, 1, 0, 32'h41,       32'h0,        32'h40,       32'h0,        32'h0,        32'h0,       0, 1};
    vt[5]  = '{1, 0, 0, 0, 32'h0,        32'h0,        32'h44,       32'h5A5A0040, 32'h40,       32'h44,      1, 1};
    vt[6]  = '{1, 0, 0, 0, 32'h0,        32'h0,        32'h48,       32'h5A5A0044, 32'h44,       32'h48,      1, 1};
    vt[7]  = '{1, 0, 1, 0, 32'h10,       32'h0,        32'h10,       32'h0,        32'h0,        32'h0,       0, 2};
    vt[8]  = '{1, 1, 1, 0, 32'h300,      32'h0,        32'h10,       32'h0,        32'h0,        32'h0,       0, 2};
    vt[9]  = '{1, 1, 1, 0, 32'h300,      32'h0,        32'h10,       32'h0,        32'h0,        32'h0,       0, 2};
    vt[10] = '{1, 1, 1, 0, 32'h300,      32'h0,        32'h10,       32'h0,        32'h0,        32'h0,       0, 2};
    vt[11] = '{1, 0, 1, 0, 32'h300,      32'h0,        32'h300,      32'h0,        32'h0,        32'h0,       0, 3};
    vt[12] = '{1, 1, 1, 1, 32'h200,      32'h100,      32'h100,      32'h0,        32'h0,        32'h0,       0, 4};
    vt[13] = '{1, 0, 0, 0, 32'h0,        32'h0,        32'h104,      32'h5A5A0100, 32'h100,      32'h104,     1, 4};
    vt[14] = '{1, 1, 0, 0, 32'h0,        32'h0,        32'h104,      32'h5A5A0100, 32'h100,      32'h104,     1, 4};
    vt[15] = '{1, 0, 0, 1, 32'h0,        32'hFFFFFFFE, 32'hFFFFFFFC, 32'h0,        32'h0,        32'h0,       0, 5};
    vt[16] = '{1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'hA5A5FFFC, 32'hFFFFFFFC, 32'h0,       1, 5};

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].rst, vt[i].st, vt[i].jc, vt[i].ja, vt[i].bt, vt[i].btg);
      tick();
      chk($sformatf("vec%0d.pc", i), bus.PCResult, vt[i].e_pc);
      chk($sformatf("vec%0d.instr", i), bus.Out_Instruction, vt[i].e_instr);
      chk($sformatf("vec%0d.opc", i), bus.Out_PC, vt[i].e_opc);
      chk($sformatf("vec%0d.opa", i), bus.Out_PCAdder, vt[i].e_opa);
      chk($sformatf("vec%0d.valid", i), {31'd0, bus.Out_Valid}, {31'd0, vt[i].e_valid});
      chk($sformatf("vec%0d.cnt", i), {16'd0, bus.Out_FlushCount}, {16'd0, vt[i].e_cnt});
      check_model($sformatf("vec%0d.model", i));
    end

    // Randomized run, including resets landing mid-stall and mid-redirect
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), $urandom(),
            ($urandom_range(0, 5) == 0), $urandom());
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    // Long flush run for counter saturation
    drive(0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 70000; i++) begin
      drive(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom(), 1, $urandom());
      tick();
    end
    check_model("sat");
    chk("sat.cnt", {16'd0, bus.Out_FlushCount}, 32'h0000_FFFF);
    drive(1, 0, 1, 32'h80, 0, 0);
    tick();
    chk("sat.hold", {16'd0, bus.Out_FlushCount}, 32'h0000_FFFF);
    check_model("sat2");
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("sat.reset", {16'd0, bus.Out_FlushCount}, 32'h0);
    check_model("sat3");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
